// File: rtl/cnn_mac_pkg.sv
// rtl/cnn_mac_pkg.sv - shared helpers and mode constants for the pipelined CNN MAC
package cnn_mac_pkg;

  // Result domain: signed as soon as either operand is two's complement.
  typedef enum logic {
    RES_UNSIGNED = 1'b0,
    RES_SIGNED   = 1'b1
  } res_mode_e;

  // Full product width of the sign-extended operands (each operand gains one bit).
  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 2;
  endfunction

  function automatic res_mode_e res_mode(input bit s0, input bit s1);
    return (s0 | s1) ? RES_SIGNED : RES_UNSIGNED;
  endfunction

  // Largest representable result for a given output width and domain.
  function automatic logic signed [63:0] clip_max(input int dw, input res_mode_e m);
    if (m == RES_SIGNED) return (64'sd1 <<< (dw - 1)) - 64'sd1;
    return (64'sd1 <<< dw) - 64'sd1;
  endfunction

  // Smallest representable result for a given output width and domain.
  function automatic logic signed [63:0] clip_min(input int dw, input res_mode_e m);
    if (m == RES_SIGNED) return -(64'sd1 <<< (dw - 1));
    return 64'sd0;
  endfunction

endpackage

// File: rtl/cnn_mul_acc_pipe_if.sv
// rtl/cnn_mul_acc_pipe_if.sv - operand/result handshake bundle of the CNN MAC
interface cnn_mul_acc_pipe_if #(
  parameter int DIN0_WIDTH = 10,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 21
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  in_first;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  dout_sat;

  // Fetch/activation side: drives operands, consumes results.
  modport master (
    output in_valid, din0, din1, in_first, in_last, out_ready,
    input  in_ready, out_valid, dout, dout_sat
  );

  // MAC side.
  modport slave (
    input  in_valid, din0, din1, in_first, in_last, out_ready,
    output in_ready, out_valid, dout, dout_sat
  );
endinterface

// File: rtl/cnn_mul_pipe.sv
// rtl/cnn_mul_pipe.sv - operand extension, multiply and NUM_STAGE register pipeline
module cnn_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 10,
  parameter int DIN1_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STAGE  = 2,
  parameter int SIGNED0    = 0,
  parameter int SIGNED1    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  out_prod,
  output logic                  out_first,
  output logic                  out_last
);

  localparam int PW = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  logic signed [DIN0_WIDTH:0] op0;
  logic signed [DIN1_WIDTH:0] op1;
  logic signed [PW-1:0]       prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;

  // One extra top bit makes unsigned operands look like non-negative signed ones,
  // so a single signed multiplier serves every mode combination.
  assign op0      = {((SIGNED0 != 0) ? din0[DIN0_WIDTH-1] : 1'b0), din0};
  assign op1      = {((SIGNED1 != 0) ? din1[DIN1_WIDTH-1] : 1'b0), din1};
  assign prod     = PW'(op0) * PW'(op1);
  assign prod_ext = ACC_WIDTH'(prod);

  logic                 st_valid [NUM_STAGE];
  logic [ACC_WIDTH-1:0] st_prod  [NUM_STAGE];
  logic                 st_first [NUM_STAGE];
  logic                 st_last  [NUM_STAGE];

  // Shift product and sideband through the stages; the shared enable freezes all of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        st_valid[i] <= 1'b0;
        st_prod[i]  <= '0;
        st_first[i] <= 1'b0;
        st_last[i]  <= 1'b0;
      end
    end else if (en) begin
      st_valid[0] <= in_valid;
      st_prod[0]  <= prod_ext;
      st_first[0] <= in_first;
      st_last[0]  <= in_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_prod[i]  <= st_prod[i-1];
        st_first[i] <= st_first[i-1];
        st_last[i]  <= st_last[i-1];
      end
    end
  end

  assign out_valid = st_valid[NUM_STAGE-1];
  assign out_prod  = st_prod[NUM_STAGE-1];
  assign out_first = st_first[NUM_STAGE-1];
  assign out_last  = st_last[NUM_STAGE-1];

endmodule

// File: rtl/cnn_mul_acc_pipe.sv
// rtl/cnn_mul_acc_pipe.sv - pipelined multiply-accumulate with grouped sums and saturated result
module cnn_mul_acc_pipe #(
  parameter int DIN0_WIDTH = 10,
  parameter int DIN1_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 21,
  parameter int NUM_STAGE  = 2,
  parameter int SIGNED0    = 0,
  parameter int SIGNED1    = 0
) (
  input logic         ap_clk,
  input logic         ap_rst_n,
  cnn_mul_acc_pipe_if.slave bus
);
  import cnn_mac_pkg::*;

  localparam res_mode_e MODE = res_mode(SIGNED0 != 0, SIGNED1 != 0);
  localparam logic [ACC_WIDTH-1:0] CLIP_HI = ACC_WIDTH'(clip_max(DOUT_WIDTH, MODE));
  localparam logic [ACC_WIDTH-1:0] CLIP_LO = ACC_WIDTH'(clip_min(DOUT_WIDTH, MODE));

  logic                  advance;
  logic                  out_valid_q;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic                  sat_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [ACC_WIDTH-1:0]  acc_next;
  logic [DOUT_WIDTH-1:0] dout_next;
  logic                  sat_next;

  logic                  m_valid;
  logic [ACC_WIDTH-1:0]  m_prod;
  logic                  m_first;
  logic                  m_last;

  // A pending unconsumed result stalls the whole pipe; nothing moves, no bubbles appear.
  assign advance       = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = advance & ap_rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.dout_sat  = sat_q;

  cnn_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .NUM_STAGE  (NUM_STAGE),
    .SIGNED0    (SIGNED0),
    .SIGNED1    (SIGNED1)
  ) u_mul (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .en        (advance),
    .in_valid  (bus.in_valid & bus.in_ready),
    .din0      (bus.din0),
    .din1      (bus.din1),
    .in_first  (bus.in_first),
    .in_last   (bus.in_last),
    .out_valid (m_valid),
    .out_prod  (m_prod),
    .out_first (m_first),
    .out_last  (m_last)
  );

  // Next accumulator value and its clipped image in the result domain.
  always_comb begin
    acc_next  = m_first ? m_prod : acc_q + m_prod;
    dout_next = acc_next[DOUT_WIDTH-1:0];
    sat_next  = 1'b0;
    if (MODE == RES_SIGNED) begin
      if ($signed(acc_next) > $signed(CLIP_HI)) begin
        dout_next = CLIP_HI[DOUT_WIDTH-1:0];
        sat_next  = 1'b1;
      end else if ($signed(acc_next) < $signed(CLIP_LO)) begin
        dout_next = CLIP_LO[DOUT_WIDTH-1:0];
        sat_next  = 1'b1;
      end
    end else if (acc_next > CLIP_HI) begin
      dout_next = CLIP_HI[DOUT_WIDTH-1:0];
      sat_next  = 1'b1;
    end
  end

  // Accumulator only moves on real beats; it wraps freely.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q <= '0;
    end else if (advance && m_valid) begin
      acc_q <= acc_next;
    end
  end

  // Output register: loads on a group's last beat, otherwise holds data and drops valid.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= m_valid & m_last;
      if (m_valid && m_last) begin
        dout_q <= dout_next;
        sat_q  <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_cnn_mul_acc_pipe.sv
// tb/tb_cnn_mul_acc_pipe.sv - directed self-checking bench for cnn_mul_acc_pipe
module tb_cnn_mul_acc_pipe;

  typedef struct {
    logic [20:0] d;
    logic        s;
    int          c;
  } rec_t;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   beat_cyc = 0;
  rec_t q[$];

  always #5 ap_clk = ~ap_clk;

  cnn_mul_acc_pipe_if #(.DIN0_WIDTH(10), .DIN1_WIDTH(12), .DOUT_WIDTH(21)) bus ();
  cnn_mul_acc_pipe_if #(.DIN0_WIDTH(10), .DIN1_WIDTH(12), .DOUT_WIDTH(21)) sbus ();

  cnn_mul_acc_pipe dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave)
  );

  cnn_mul_acc_pipe #(.SIGNED0(1), .SIGNED1(1)) dut_s (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (sbus.slave)
  );

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Record every result handshake of the unsigned instance with its cycle number.
  always @(negedge ap_clk) begin
    if (bus.out_valid && bus.out_ready) q.push_back('{bus.dout, bus.dout_sat, cyc});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ap_clk);
    #2;
  endtask

  task automatic send(input logic [9:0] d0, input logic [11:0] d1, input logic f, input logic l);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.din0     = d0;
    bus.din1     = d1;
    bus.in_first = f;
    bus.in_last  = l;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      ok       = bus.in_ready;
      beat_cyc = cyc;
      tick();
    end
    if (!ok) begin
      total++;
      $display("FAIL send_accept: beat (%0d,%0d) not accepted within 20 cycles", d0, d1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int k = 0; k < budget && q.size() < n; k++) tick();
    total++;
    if (q.size() < n) $display("FAIL result_timeout: got %0d results, required %0d", q.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    ap_rst_n       = 1'b0;
    bus.in_valid   = 1'b0;
    bus.din0       = '0;
    bus.din1       = '0;
    bus.in_first   = 1'b0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;
    sbus.in_valid  = 1'b0;
    sbus.din0      = '0;
    sbus.din1      = '0;
    sbus.in_first  = 1'b0;
    sbus.in_last   = 1'b0;
    sbus.out_ready = 1'b1;
    tick();
    tick();
    #1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0d, required 0", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0d, required 0", bus.out_valid); else passed++;
    total++; if (bus.dout !== 21'd0) $display("FAIL reset_dout: got %0d, required 0", bus.dout); else passed++;
    total++; if (bus.dout_sat !== 1'b0) $display("FAIL reset_dout_sat: got %0d, required 0", bus.dout_sat); else passed++;
    ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_sat();
    q.delete();
    send(10'd1023, 12'd4095, 1'b1, 1'b1);
    wait_results(1, 10);
    if (q.size() >= 1) begin
      total++; if (q[0].d !== 21'd2097151) $display("FAIL single_dout: got %0d, required 2097151", q[0].d); else passed++;
      total++; if (q[0].s !== 1'b1) $display("FAIL single_sat: got %0d, required 1", q[0].s); else passed++;
      total++; if (q[0].c - beat_cyc !== 3) $display("FAIL single_latency: got %0d, required 3", q[0].c - beat_cyc); else passed++;
    end
    total++; if (bus.out_valid !== 1'b0) $display("FAIL single_valid_clear: got %0d, required 0", bus.out_valid); else passed++;
  endtask

  task automatic test_group();
    q.delete();
    send(10'd3, 12'd5, 1'b1, 1'b0);
    send(10'd7, 12'd11, 1'b0, 1'b0);
    send(10'd2, 12'd100, 1'b0, 1'b1);
    wait_results(1, 10);
    tick();
    tick();
    tick();
    total++; if (q.size() !== 1) $display("FAIL group_count: got %0d, required 1", q.size()); else passed++;
    if (q.size() >= 1) begin
      total++; if (q[0].d !== 21'd292) $display("FAIL group_dout: got %0d, required 292", q[0].d); else passed++;
      total++; if (q[0].s !== 1'b0) $display("FAIL group_sat: got %0d, required 0", q[0].s); else passed++;
    end
  endtask

  task automatic test_stall();
    q.delete();
    bus.out_ready = 1'b0;
    send(10'd6, 12'd7, 1'b1, 1'b1);
    send(10'd2, 12'd3, 1'b1, 1'b0);
    send(10'd4, 12'd5, 1'b0, 1'b1);
    for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
    bus.in_valid = 1'b1;
    bus.din0     = 10'd1;
    bus.din1     = 12'd9;
    bus.in_first = 1'b1;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %0d, required 0", k, bus.in_ready); else passed++;
      total++; if (bus.out_valid !== 1'b1) $display("FAIL stall_out_valid[%0d]: got %0d, required 1", k, bus.out_valid); else passed++;
      total++; if (bus.dout !== 21'd42) $display("FAIL stall_dout[%0d]: got %0d, required 42", k, bus.dout); else passed++;
      tick();
    end
    bus.out_ready = 1'b1;
    send(10'd1, 12'd9, 1'b1, 1'b1);
    wait_results(3, 20);
    tick();
    tick();
    tick();
    total++; if (q.size() !== 3) $display("FAIL stall_count: got %0d, required 3", q.size()); else passed++;
    if (q.size() >= 3) begin
      total++; if (q[0].d !== 21'd42) $display("FAIL stall_res0: got %0d, required 42", q[0].d); else passed++;
      total++; if (q[1].d !== 21'd26) $display("FAIL stall_res1: got %0d, required 26", q[1].d); else passed++;
      total++; if (q[2].d !== 21'd9) $display("FAIL stall_res2: got %0d, required 9", q[2].d); else passed++;
    end
  endtask

  task automatic test_signed();
    logic signed [20:0] exp_neg;
    exp_neg = -21'sd1048064;
    sbus.in_valid = 1'b1;
    sbus.din0     = 10'h200;
    sbus.din1     = 12'h800;
    sbus.in_first = 1'b1;
    sbus.in_last  = 1'b1;
    tick();
    sbus.in_valid = 1'b0;
    for (int k = 0; k < 10 && !sbus.out_valid; k++) tick();
    total++; if (sbus.out_valid !== 1'b1) $display("FAIL signed_pos_valid: got %0d, required 1", sbus.out_valid); else passed++;
    total++; if (sbus.dout !== 21'd1048575) $display("FAIL signed_pos_dout: got %0d, required 1048575", sbus.dout); else passed++;
    total++; if (sbus.dout_sat !== 1'b1) $display("FAIL signed_pos_sat: got %0d, required 1", sbus.dout_sat); else passed++;
    tick();
    sbus.in_valid = 1'b1;
    sbus.din0     = 10'h200;
    sbus.din1     = 12'h7FF;
    tick();
    sbus.in_valid = 1'b0;
    for (int k = 0; k < 10 && !sbus.out_valid; k++) tick();
    total++; if (sbus.out_valid !== 1'b1) $display("FAIL signed_neg_valid: got %0d, required 1", sbus.out_valid); else passed++;
    total++; if (sbus.dout !== exp_neg) $display("FAIL signed_neg_dout: got %0d, required %0d", $signed(sbus.dout), exp_neg); else passed++;
    total++; if (sbus.dout_sat !== 1'b0) $display("FAIL signed_neg_sat: got %0d, required 0", sbus.dout_sat); else passed++;
  endtask

  task automatic test_reset_mid_group();
    bus.out_ready = 1'b0;
    send(10'd3, 12'd3, 1'b1, 1'b1);
    send(10'd5, 12'd5, 1'b1, 1'b0);
    send(10'd6, 12'd6, 1'b0, 1'b0);
    for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
    ap_rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %0d, required 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_mid_in_ready: got %0d, required 0", bus.in_ready); else passed++;
    total++; if (bus.dout !== 21'd0) $display("FAIL rst_mid_dout: got %0d, required 0", bus.dout); else passed++;
    tick();
    tick();
    ap_rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    q.delete();
    send(10'd4, 12'd4, 1'b0, 1'b1);
    wait_results(1, 10);
    if (q.size() >= 1) begin
      total++; if (q[0].d !== 21'd16) $display("FAIL rst_nofirst_dout: got %0d, required 16", q[0].d); else passed++;
    end
    q.delete();
    send(10'd4, 12'd4, 1'b1, 1'b1);
    wait_results(1, 10);
    if (q.size() >= 1) begin
      total++; if (q[0].d !== 21'd16) $display("FAIL rst_single_dout: got %0d, required 16", q[0].d); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    q.delete();
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(10'(i), 12'(i), 1'b1, 1'b1);
    wait_results(8, 20);
    tick();
    tick();
    total++; if (q.size() !== 8) $display("FAIL b2b_count: got %0d, required 8", q.size()); else passed++;
    if (q.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        total++; if (q[k].d !== 21'((k + 1) * (k + 1))) $display("FAIL b2b_dout[%0d]: got %0d, required %0d", k, q[k].d, (k + 1) * (k + 1)); else passed++;
        total++; if (q[k].c !== q[0].c + k) $display("FAIL b2b_cycle[%0d]: got %0d, required %0d", k, q[k].c, q[0].c + k); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_sat();
    test_group();
    test_stall();
    test_signed();
    test_reset_mid_group();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
